// File: rtl/elbeth_alu_issue.sv
// Operand-issue register ahead of elbeth_alu: forwards MEM/WB results into operands,
// stalls on load-use hazards and hands registered operands to EX under valid/ready.
module elbeth_alu_issue #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned OP_WIDTH       = 4,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [DATA_WIDTH-1:0]     rs1_data,
  input  logic [DATA_WIDTH-1:0]     rs2_data,
  input  logic [DATA_WIDTH-1:0]     imm,
  input  logic                      use_imm,
  input  logic [OP_WIDTH-1:0]       alu_op,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic                      reg_write,
  input  logic                      mem_fwd_we,
  input  logic [REG_ADDR_WIDTH-1:0] mem_fwd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_fwd_data,
  input  logic                      mem_is_load,
  input  logic                      wb_fwd_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_fwd_addr,
  input  logic [DATA_WIDTH-1:0]     wb_fwd_data,
  input  logic                      flush,
  input  logic                      ex_ready,
  output logic                      ex_valid,
  output logic [DATA_WIDTH-1:0]     data_a,
  output logic [DATA_WIDTH-1:0]     data_b,
  output logic [OP_WIDTH-1:0]       operation,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  output logic                      ex_reg_write,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  logic                  hazard;
  logic                  slot_free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] res_a;
  logic [DATA_WIDTH-1:0] res_b;

  // MEM beats WB; a load in MEM has no data yet and never forwards.
  function automatic logic [DATA_WIDTH-1:0] resolve(
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0]     rf_data
  );
    logic [DATA_WIDTH-1:0] r;
    r = rf_data;
    if (addr == '0)
      r = '0;
    else if (mem_fwd_we && (mem_fwd_addr == addr) && !mem_is_load)
      r = mem_fwd_data;
    else if (wb_fwd_we && (wb_fwd_addr == addr))
      r = wb_fwd_data;
    return r;
  endfunction

  always_comb begin
    res_a = resolve(rs1_addr, rs1_data);
    res_b = resolve(rs2_addr, rs2_data);
  end

  assign hazard = in_valid && mem_fwd_we && mem_is_load && (mem_fwd_addr != '0) &&
                  ((mem_fwd_addr == rs1_addr) || (!use_imm && (mem_fwd_addr == rs2_addr)));
  assign slot_free = !ex_valid || ex_ready;
  assign in_ready  = slot_free && !hazard;
  assign accept    = in_valid && in_ready;

  // Flush leaves data fields stale; only valid and write-enable are killed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      data_a       <= '0;
      data_b       <= '0;
      operation    <= '0;
      ex_rd_addr   <= '0;
      ex_reg_write <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      if (hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (flush) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
      end else if (accept) begin
        ex_valid     <= 1'b1;
        data_a       <= res_a;
        data_b       <= use_imm ? imm : res_b;
        operation    <= alu_op;
        ex_rd_addr   <= rd_addr;
        ex_reg_write <= reg_write;
      end else if (slot_free) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_elbeth_alu_issue.sv
// Scoreboard bench for elbeth_alu_issue: expected outputs queued on accept, checked
// every cycle while held and retired on the EX handshake.
module tb_elbeth_alu_issue;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned OW = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [AW-1:0] rs1_addr, rs2_addr, rd_addr, mem_fwd_addr, wb_fwd_addr, ex_rd_addr;
  logic [DW-1:0] rs1_data, rs2_data, imm, mem_fwd_data, wb_fwd_data, data_a, data_b;
  logic          use_imm, reg_write, mem_fwd_we, mem_is_load, wb_fwd_we, flush, ex_ready;
  logic [OW-1:0] alu_op, operation;
  logic          ex_valid, ex_reg_write;
  logic [CW-1:0] stall_cnt;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
    logic [AW-1:0] rd;
    logic          rw;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  logic [CW-1:0] m_stall;
  int            n_tests = 0;
  int            n_fail  = 0;

  elbeth_alu_issue #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .OP_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .use_imm(use_imm), .alu_op(alu_op), .rd_addr(rd_addr), .reg_write(reg_write),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
    .mem_is_load(mem_is_load), .wb_fwd_we(wb_fwd_we), .wb_fwd_addr(wb_fwd_addr),
    .wb_fwd_data(wb_fwd_data), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .data_a(data_a), .data_b(data_b), .operation(operation), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    rs1_addr = '0; rs2_addr = '0; rs1_data = '0; rs2_data = '0; imm = '0; use_imm = 1'b0;
    alu_op = '0; rd_addr = '0; reg_write = 1'b0;
    mem_fwd_we = 1'b0; mem_fwd_addr = '0; mem_fwd_data = '0; mem_is_load = 1'b0;
    wb_fwd_we = 1'b0; wb_fwd_addr = '0; wb_fwd_data = '0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(ex_valid), 64'd0);
    check_eq({tag, "_a"},     64'(data_a), 64'd0);
    check_eq({tag, "_b"},     64'(data_b), 64'd0);
    check_eq({tag, "_op"},    64'(operation), 64'd0);
    check_eq({tag, "_rd"},    64'(ex_rd_addr), 64'd0);
    check_eq({tag, "_rw"},    64'(ex_reg_write), 64'd0);
    check_eq({tag, "_stall"}, 64'(stall_cnt), 64'd0);
  endtask

  // One clock: inputs are already set; check current outputs, advance the scoreboard.
  task automatic cycle();
    logic haz, sf, rdy, acc;
    exp_t h;
    haz = in_valid && mem_fwd_we && mem_is_load && (mem_fwd_addr != 0) &&
          ((mem_fwd_addr == rs1_addr) || (!use_imm && (mem_fwd_addr == rs2_addr)));
    sf  = (sb.size() == 0) || ex_ready;
    rdy = sf && !haz;
    acc = in_valid && rdy;
    #1;
    check_eq("in_ready", 64'(in_ready), 64'(rdy));
    check_eq("ex_valid", 64'(ex_valid), 64'(sb.size() != 0));
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (sb.size() != 0) begin
      h = sb[0];
      check_eq("data_a", 64'(data_a), 64'(h.a));
      check_eq("data_b", 64'(data_b), 64'(h.b));
      check_eq("operation", 64'(operation), 64'(h.op));
      check_eq("ex_rd_addr", 64'(ex_rd_addr), 64'(h.rd));
      check_eq("ex_reg_write", 64'(ex_reg_write), 64'(h.rw));
    end else begin
      check_eq("idle_reg_write", 64'(ex_reg_write), 64'd0);
    end
    if (rst) begin
      sb.delete();
      m_stall = '0;
    end else begin
      if (haz && (m_stall != '1)) m_stall = m_stall + CW'(1);
      if (flush) sb.delete();
      else begin
        if ((sb.size() != 0) && ex_ready) void'(sb.pop_front());
        if (acc) sb.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                           input logic [AW-1:0] r2, input logic [DW-1:0] d2,
                           input logic [OW-1:0] op, input logic [AW-1:0] rd,
                           input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    in_valid = 1'b1; rs1_addr = r1; rs1_data = d1; rs2_addr = r2; rs2_data = d2;
    alu_op = op; rd_addr = rd; reg_write = 1'b1;
    e = '{a: ea, b: eb, op: op, rd: rd, rw: 1'b1};
  endtask

  initial begin
    idle_inputs();
    m_stall = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Basic issue from register file
    set_instr(5'd3, 32'd3, 5'd4, 32'd4, 4'd0, 5'd1, 32'd3, 32'd4);
    cycle();
    in_valid = 1'b0;
    cycle();

    // Forwarding priority: MEM over WB over RF, x0 always zero
    use_imm = 1'b1; imm = 32'h55;
    wb_fwd_we = 1'b1; wb_fwd_addr = 5'd7; wb_fwd_data = 32'd20;
    mem_fwd_we = 1'b1; mem_fwd_addr = 5'd7; mem_fwd_data = 32'd10;
    set_instr(5'd7, 32'd1, 5'd0, 32'd0, 4'd1, 5'd2, 32'd10, 32'h55);
    cycle();
    mem_fwd_we = 1'b0;
    e.a = 32'd20;
    cycle();
    mem_fwd_we = 1'b1; mem_fwd_addr = 5'd0;
    set_instr(5'd0, 32'd9, 5'd0, 32'd0, 4'd3, 5'd3, 32'd0, 32'h55);
    cycle();
    use_imm = 1'b0; mem_fwd_addr = 5'd7;
    set_instr(5'd2, 32'd2, 5'd7, 32'd8, 4'd5, 5'd4, 32'd2, 32'd10);
    cycle();
    in_valid = 1'b0; mem_fwd_we = 1'b0; wb_fwd_we = 1'b0;
    cycle();

    // Back-pressure: held outputs stay put, new instruction waits
    set_instr(5'd11, 32'd11, 5'd12, 32'd12, 4'd2, 5'd5, 32'd11, 32'd12);
    cycle();
    ex_ready = 1'b0;
    set_instr(5'd13, 32'd13, 5'd14, 32'd14, 4'd6, 5'd6, 32'd13, 32'd14);
    repeat (3) cycle();
    check_eq("bp_hold_a", 64'(data_a), 64'd11);
    ex_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check_eq("bp_new_a", 64'(data_a), 64'd13);
    cycle();

    // Load-use on rs2 stalls; same with immediate does not
    mem_fwd_we = 1'b1; mem_is_load = 1'b1; mem_fwd_addr = 5'd5; mem_fwd_data = 32'hdead;
    set_instr(5'd1, 32'd1, 5'd5, 32'd7, 4'd0, 5'd8, 32'd1, 32'd7);
    cycle();
    check_eq("stall_one", 64'(stall_cnt), 64'd1);
    check_eq("bubble", 64'(ex_valid), 64'd0);
    use_imm = 1'b1; imm = 32'h77; e.b = 32'h77;
    cycle();
    in_valid = 1'b0; use_imm = 1'b0; mem_fwd_we = 1'b0; mem_is_load = 1'b0;
    cycle();

    // Flush kills an incoming and a held instruction
    flush = 1'b1;
    set_instr(5'd2, 32'd2, 5'd3, 32'd3, 4'd1, 5'd9, 32'd2, 32'd3);
    cycle();
    flush = 1'b0;
    check_eq("flush_valid", 64'(ex_valid), 64'd0);
    check_eq("flush_rw", 64'(ex_reg_write), 64'd0);
    cycle();
    ex_ready = 1'b0; in_valid = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0; ex_ready = 1'b1;
    cycle();

    // Reset in the middle of back-pressure
    set_instr(5'd4, 32'd4, 5'd6, 32'd6, 4'd3, 5'd10, 32'd4, 32'd6);
    cycle();
    ex_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
    check_zero("mid_rst");

    // Stall counter saturates and does not wrap
    mem_fwd_we = 1'b1; mem_is_load = 1'b1; mem_fwd_addr = 5'd9;
    set_instr(5'd9, 32'd0, 5'd0, 32'd0, 4'd0, 5'd1, 32'd0, 32'd0);
    repeat ((1 << CW) + 5) cycle();
    check_eq("stall_sat", 64'(stall_cnt), 64'((1 << CW) - 1));
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_zero("final_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
